// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined IEEE-754 single-precision multiplier with valid/ready
// flow control and an optional negated-product (fnmul) mode.
// Denormal inputs flush to zero, NaN inputs behave as infinity, and results
// that fall below the normal range flush to signed zero. The whole pipe moves
// as one: every stage advances when the output slot is empty or being taken.
module fmul_pipe #(
    parameter int LATENCY = 3,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic             neg,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic             ovf,
    output logic [TAG_W-1:0] tag_out
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("fmul_pipe: LATENCY must be in the range 1..4");
    end

    // Operand class after the special-value rules have been applied.
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    // After unpack: raw 48-bit mantissa product and unnormalised exponent.
    typedef struct packed {
        logic              v;
        logic              s;
        cls_e              cls;
        logic signed [9:0] ex;
        logic [47:0]       prod;
        logic [TAG_W-1:0]  tag;
    } st1_t;

    // After normalisation: 24-bit mantissa plus guard/round/sticky.
    typedef struct packed {
        logic              v;
        logic              s;
        cls_e              cls;
        logic signed [9:0] ex;
        logic [23:0]       mant;
        logic              g;
        logic              r;
        logic              st;
        logic [TAG_W-1:0]  tag;
    } st2_t;

    // Packed result.
    typedef struct packed {
        logic             v;
        logic             ovf;
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
    } st3_t;

    logic  adv_s;
    st3_t  out_q;
    st1_t  s1_d;
    st1_t  s1_s;
    st2_t  s2_d;
    st2_t  s2_s;
    st3_t  s3_d;
    st3_t  s3_s;

    logic  z1_s;
    logic  z2_s;
    logic  i1_s;
    logic  i2_s;

    logic              rup_s;
    logic [24:0]       rnd_s;
    logic [22:0]       frac_s;
    logic signed [9:0] ex_f_s;

    // Whole pipe shifts when the output slot is free or being consumed.
    assign adv_s    = !out_q.v || out_ready;
    assign in_ready = adv_s;

    assign z1_s = (x1[30:23] == 8'd0);
    assign z2_s = (x2[30:23] == 8'd0);
    assign i1_s = (x1[30:23] == 8'hFF);
    assign i2_s = (x2[30:23] == 8'hFF);

    // Unpack, classify operands, multiply mantissas and sum exponents.
    always_comb begin
        s1_d      = '0;
        s1_d.v    = in_valid;
        s1_d.s    = x1[31] ^ x2[31] ^ neg;
        s1_d.tag  = tag_in;
        s1_d.ex   = $signed({2'b00, x1[30:23]}) + $signed({2'b00, x2[30:23]}) - 10'sd127;
        s1_d.prod = {24'd0, 1'b1, x1[22:0]} * {24'd0, 1'b1, x2[22:0]};
        if ((z1_s && i2_s) || (i1_s && z2_s)) begin
            s1_d.cls = CLS_NAN;
        end else if (i1_s || i2_s) begin
            s1_d.cls = CLS_INF;
        end else if (z1_s || z2_s) begin
            s1_d.cls = CLS_ZERO;
        end else begin
            s1_d.cls = CLS_NORM;
        end
    end

    if (LATENCY >= 2) begin : g_s1
        st1_t s1_q;
        // Stage-1 register: product and exponent, held while stalled.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                s1_q <= '0;
            end else if (adv_s) begin
                s1_q <= s1_d;
            end
        end
        assign s1_s = s1_q;
    end else begin : g_s1_bypass
        assign s1_s = s1_d;
    end

    // Normalise by one bit when the product reaches [2,4), gather rounding bits.
    always_comb begin
        s2_d     = '0;
        s2_d.v   = s1_s.v;
        s2_d.s   = s1_s.s;
        s2_d.cls = s1_s.cls;
        s2_d.tag = s1_s.tag;
        if (s1_s.prod[47]) begin
            s2_d.mant = s1_s.prod[47:24];
            s2_d.g    = s1_s.prod[23];
            s2_d.r    = s1_s.prod[22];
            s2_d.st   = |s1_s.prod[21:0];
            s2_d.ex   = s1_s.ex + 10'sd1;
        end else begin
            s2_d.mant = s1_s.prod[46:23];
            s2_d.g    = s1_s.prod[22];
            s2_d.r    = s1_s.prod[21];
            s2_d.st   = |s1_s.prod[20:0];
            s2_d.ex   = s1_s.ex;
        end
    end

    if (LATENCY >= 3) begin : g_s2
        st2_t s2_q;
        // Stage-2 register: normalised mantissa and rounding bits.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                s2_q <= '0;
            end else if (adv_s) begin
                s2_q <= s2_d;
            end
        end
        assign s2_s = s2_q;
    end else begin : g_s2_bypass
        assign s2_s = s2_d;
    end

    // Round to nearest even, renormalise on carry-out, resolve specials and range.
    always_comb begin
        s3_d   = '0;
        rup_s  = s2_s.g & (s2_s.r | s2_s.st | s2_s.mant[0]);
        rnd_s  = {1'b0, s2_s.mant} + {24'd0, rup_s};
        if (rnd_s[24]) begin
            frac_s = rnd_s[23:1];
            ex_f_s = s2_s.ex + 10'sd1;
        end else begin
            frac_s = rnd_s[22:0];
            ex_f_s = s2_s.ex;
        end
        s3_d.v   = s2_s.v;
        s3_d.tag = s2_s.tag;
        case (s2_s.cls)
            CLS_NAN: begin
                s3_d.y   = {s2_s.s, 8'hFF, 23'h400000};
                s3_d.ovf = 1'b0;
            end
            CLS_INF: begin
                s3_d.y   = {s2_s.s, 8'hFF, 23'h000000};
                s3_d.ovf = 1'b0;
            end
            CLS_ZERO: begin
                s3_d.y   = {s2_s.s, 31'h0};
                s3_d.ovf = 1'b0;
            end
            CLS_NORM: begin
                if (ex_f_s >= 10'sd255) begin
                    s3_d.y   = {s2_s.s, 8'hFF, 23'h000000};
                    s3_d.ovf = 1'b1;
                end else if (ex_f_s <= 10'sd0) begin
                    s3_d.y   = {s2_s.s, 31'h0};
                    s3_d.ovf = 1'b0;
                end else begin
                    s3_d.y   = {s2_s.s, ex_f_s[7:0], frac_s};
                    s3_d.ovf = 1'b0;
                end
            end
            default: begin
                s3_d.y   = {s2_s.s, 31'h0};
                s3_d.ovf = 1'b0;
            end
        endcase
    end

    if (LATENCY == 4) begin : g_s3
        st3_t s3_q;
        // Extra retiming register for the deepest configuration.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                s3_q <= '0;
            end else if (adv_s) begin
                s3_q <= s3_d;
            end
        end
        assign s3_s = s3_q;
    end else begin : g_s3_bypass
        assign s3_s = s3_d;
    end

    // Output register: drives the result ports and holds them while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= '0;
        end else if (adv_s) begin
            out_q <= s3_s;
        end
    end

    assign out_valid = out_q.v;
    assign y         = out_q.y;
    assign ovf       = out_q.ovf;
    assign tag_out   = out_q.tag;

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: drives four fmul_pipe instances (LATENCY 1..4) with shared
// operands. Each instance has its own scoreboard queue, filled on acceptance
// from a real-arithmetic reference model and drained by a monitor that also
// checks latency, stall stability and in_ready.
module tb_fmul_pipe;

    localparam int NDUT = 4;
    localparam int TW   = 5;

    typedef struct {
        logic [31:0]   y;
        logic          ovf;
        logic [TW-1:0] tag;
        int            cyc;
        int            st;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rstn;
    logic                      in_valid;
    logic [31:0]               x1;
    logic [31:0]               x2;
    logic                      neg;
    logic [TW-1:0]             tag_in;
    logic                      out_ready;
    logic [NDUT-1:0]           acc;
    logic [NDUT-1:0]           iv;
    logic [NDUT-1:0]           rdy_w;
    logic [NDUT-1:0]           ov_w;
    logic [NDUT-1:0]           ovf_w;
    logic [NDUT-1:0][31:0]     y_w;
    logic [NDUT-1:0][TW-1:0]   tag_w;
    logic                      dir_en;
    logic [32:0]               dir_v;
    bit                        rnd_done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int pend_cnt[NDUT];

    // An instance stops seeing the operation once it has accepted it.
    assign iv = {NDUT{in_valid}} & ~acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (LATENCY=%0d): got %h, want %h", nm, k + 1, act, exp);
        end
    endtask

    // Reference: exact product in double precision, then rounded to single
    // with round-to-nearest-even; returns {ovf, y}.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic n);
        logic        s;
        int          ea;
        int          eb;
        real         p;
        logic [63:0] bits;
        int          de;
        int          fr;
        logic [28:0] rem;
        logic        rup;
        s  = a[31] ^ b[31] ^ n;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 0 && eb == 255) || (ea == 255 && eb == 0)) return {1'b0, s, 8'hFF, 23'h400000};
        if (ea == 255 || eb == 255) return {1'b0, s, 8'hFF, 23'h000000};
        if (ea == 0 || eb == 0) return {1'b0, s, 31'h0};
        p    = real'(int'({1'b1, a[22:0]})) * real'(int'({1'b1, b[22:0]})) * (2.0 ** (ea + eb - 254 - 46));
        bits = $realtobits(p);
        de   = int'(bits[62:52]) - 896;
        fr   = int'(bits[51:29]);
        rem  = bits[28:0];
        rup  = (rem > 29'h10000000) || ((rem == 29'h10000000) && fr[0]);
        fr   = fr + int'(rup);
        if (fr == 8388608) begin
            fr = 0;
            de = de + 1;
        end
        if (de >= 255) return {1'b1, s, 8'hFF, 23'h000000};
        if (de <= 0) return {1'b0, s, 31'h0};
        return {1'b0, s, de[7:0], fr[22:0]};
    endfunction

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        fmul_pipe #(.LATENCY(k + 1), .TAG_W(TW)) u_dut (
            .clk      (clk),
            .rstn     (rstn),
            .in_valid (iv[k]),
            .in_ready (rdy_w[k]),
            .x1       (x1),
            .x2       (x2),
            .neg      (neg),
            .tag_in   (tag_in),
            .out_valid(ov_w[k]),
            .out_ready(out_ready),
            .y        (y_w[k]),
            .ovf      (ovf_w[k]),
            .tag_out  (tag_w[k])
        );

        exp_t          q[$];
        int            stalls = 0;
        logic          held = 1'b0;
        logic [31:0]   hy;
        logic          hovf;
        logic [TW-1:0] htag;

        always @(negedge rstn) begin
            q.delete();
            pend_cnt[k] = 0;
            held = 1'b0;
        end

        always @(negedge clk) begin
            exp_t        e;
            logic [32:0] r;
            if (rstn === 1'b1) begin
                if (held) begin
                    chk("stall_hold_y", k, 64'(y_w[k]), 64'(hy));
                    chk("stall_hold_ovf", k, 64'(ovf_w[k]), 64'(hovf));
                    chk("stall_hold_tag", k, 64'(tag_w[k]), 64'(htag));
                    chk("stall_hold_valid", k, 64'(ov_w[k]), 64'h1);
                end
                chk("in_ready", k, 64'(rdy_w[k]), 64'(!ov_w[k] || out_ready));
                if (ov_w[k] && out_ready) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_output (LATENCY=%0d): got y=%h tag=%0d, want no result", k + 1, y_w[k], tag_w[k]);
                    end else begin
                        e = q.pop_front();
                        pend_cnt[k]--;
                        chk("y", k, 64'(y_w[k]), 64'(e.y));
                        chk("ovf", k, 64'(ovf_w[k]), 64'(e.ovf));
                        chk("tag_order", k, 64'(tag_w[k]), 64'(e.tag));
                        chk("latency", k, 64'(cyc - e.cyc), 64'(k + 1 + stalls - e.st));
                    end
                end
                if (iv[k] && rdy_w[k]) begin
                    r     = dir_en ? dir_v : ref_mul(x1, x2, neg);
                    e.y   = r[31:0];
                    e.ovf = r[32];
                    e.tag = tag_in;
                    e.cyc = cyc;
                    e.st  = stalls;
                    q.push_back(e);
                    pend_cnt[k]++;
                end
                held = ov_w[k] && !out_ready;
                if (held) begin
                    hy   = y_w[k];
                    hovf = ovf_w[k];
                    htag = tag_w[k];
                    stalls++;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Present one operation until every instance has taken it.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic n,
                         input logic [TW-1:0] t, input logic de, input logic [32:0] dv);
        logic [NDUT-1:0] nxt;
        bit              ok;
        x1       = a;
        x2       = b;
        neg      = n;
        tag_in   = t;
        dir_en   = de;
        dir_v    = dv;
        acc      = '0;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            nxt = acc | (iv & rdy_w);
            @(posedge clk);
            #1;
            acc = nxt;
            ok  = &acc;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: got accepted mask %b, want %b", acc, {NDUT{1'b1}});
        end
        in_valid = 1'b0;
        acc      = '0;
        dir_en   = 1'b0;
    endtask

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(15) == 0) begin
            v[30:23] = ($urandom_range(1) == 1) ? 8'hFF : 8'h00;
        end else begin
            v[30:23] = 8'($urandom_range(254, 1));
        end
        return v;
    endfunction

    // Avoid products whose rounding straddles the bottom of the normal range,
    // where flushing before and after rounding legitimately differ.
    task automatic rand_pair(output logic [31:0] a, output logic [31:0] b);
        int s;
        a = rand_opnd();
        b = rand_opnd();
        for (int i = 0; i < 100; i++) begin
            s = int'(a[30:23]) + int'(b[30:23]);
            if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF) break;
            if (s != 126 && s != 127) break;
            b = rand_opnd();
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((pend_cnt[0] + pend_cnt[1] + pend_cnt[2] + pend_cnt[3]) != 0 && i < 1000) begin
            @(posedge clk);
            i++;
        end
        #1;
        for (int k = 0; k < NDUT; k++) chk("drain_empty", k, 64'(pend_cnt[k]), 64'h0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got simulation time limit, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        x1        = 32'h0;
        x2        = 32'h0;
        neg       = 1'b0;
        tag_in    = '0;
        out_ready = 1'b1;
        acc       = '0;
        dir_en    = 1'b0;
        dir_v     = 33'h0;
        rnd_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_out_valid", k, 64'(ov_w[k]), 64'h0);
            chk("rst_y", k, 64'(y_w[k]), 64'h0);
            chk("rst_ovf", k, 64'(ovf_w[k]), 64'h0);
            chk("rst_tag", k, 64'(tag_w[k]), 64'h0);
            chk("rst_in_ready", k, 64'(rdy_w[k]), 64'h1);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Directed values, issued back to back at full rate.
        issue(32'h3FC00000, 32'h40000000, 1'b0, 5'd7, 1'b1, {1'b0, 32'h40400000});
        issue(32'h3F800001, 32'h3F800001, 1'b0, 5'd8, 1'b1, {1'b0, 32'h3F800002});
        issue(32'h40000000, 32'h40000000, 1'b1, 5'd9, 1'b1, {1'b0, 32'hC0800000});
        issue(32'h7F000000, 32'h7F000000, 1'b0, 5'd10, 1'b1, {1'b1, 32'h7F800000});
        issue(32'h7F800000, 32'h3F800000, 1'b0, 5'd11, 1'b1, {1'b0, 32'h7F800000});
        issue(32'h00400000, 32'h3F800000, 1'b0, 5'd12, 1'b1, {1'b0, 32'h00000000});
        issue(32'h00000000, 32'hFF800000, 1'b0, 5'd13, 1'b1, {1'b0, 32'hFFC00000});
        drain();

        // Eight-operation stream with a three-cycle output stall mid-stream.
        fork
            begin
                for (int t = 0; t < 8; t++) begin
                    rand_pair(a, b);
                    issue(a, b, 1'($urandom_range(1)), 5'(t), 1'b0, 33'h0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset pulse with two operations in flight.
        rand_pair(a, b);
        issue(a, b, 1'b0, 5'd20, 1'b0, 33'h0);
        rand_pair(a, b);
        issue(a, b, 1'b0, 5'd21, 1'b0, 33'h0);
        #1;
        rstn = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("midrst_out_valid", k, 64'(ov_w[k]), 64'h0);
            chk("midrst_y", k, 64'(y_w[k]), 64'h0);
            chk("midrst_ovf", k, 64'(ovf_w[k]), 64'h0);
            chk("midrst_tag", k, 64'(tag_w[k]), 64'h0);
            chk("midrst_in_ready", k, 64'(rdy_w[k]), 64'h1);
        end
        #1;
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue(32'h3FC00000, 32'h40000000, 1'b0, 5'd22, 1'b1, {1'b0, 32'h40400000});
        drain();

        // Randomised operands with random backpressure and idle cycles.
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2;
                    out_ready = ($urandom_range(3) != 0);
                end
            end
            begin
                for (int i = 0; i < 10000; i++) begin
                    rand_pair(a, b);
                    issue(a, b, 1'($urandom_range(1)), 5'($urandom), 1'b0, 33'h0);
                    if ($urandom_range(7) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
        join
        #3;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
